// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from active-low h/v sync,
// measures line and frame periods, and locks once a whole frame matches
// the configured mode. Pins reach the outputs through three register
// stages (two synchroniser flops plus the output register).
module vga_sync_receiver #(
    parameter int H_TOTAL  = 800,
    parameter int H_ACTIVE = 640,
    parameter int H_BP     = 48,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        red_in,
    input  logic        green_in,
    input  logic        blue_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic [2:0]  rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] H_START = 11'(H_BP);
    localparam logic [10:0] H_END   = 11'(H_BP + H_ACTIVE);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0]  V_START = 10'(V_BP);
    localparam logic [9:0]  V_END   = 10'(V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Synchroniser and edge-detect registers; sync flops idle high.
    logic       hs_meta, hs_sync, hs_prev;
    logic       vs_meta, vs_sync, vs_prev;
    logic [2:0] rgb_d1, rgb_d2;
    logic       hs_fall, hs_rise, vs_rise;

    // Timing counters and measurement captures.
    logic [10:0] hcnt, hcnt_nxt;
    logic [9:0]  vcnt, vcnt_nxt;
    logic [10:0] lcnt;
    logic        have_fall;
    logic        line_cap, frame_cap;
    logic        line_err, frame_err;

    // Lock tracking.
    state_t state;
    logic   line_bad;

    // Output qualification from the values being loaded this cycle.
    logic h_act, v_act, pix_ok;

    // Two-flop synchronisers on the syncs, with an equal delay on colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_meta <= 1'b1;
            hs_sync <= 1'b1;
            hs_prev <= 1'b1;
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
            rgb_d1  <= '0;
            rgb_d2  <= '0;
        end else begin
            hs_meta <= vga_h_sync;
            hs_sync <= hs_meta;
            hs_prev <= hs_sync;
            vs_meta <= vga_v_sync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            rgb_d1  <= {red_in, green_in, blue_in};
            rgb_d2  <= rgb_d1;
        end
    end

    assign hs_fall = hs_prev & ~hs_sync;
    assign hs_rise = ~hs_prev & hs_sync;
    assign vs_rise = ~vs_prev & vs_sync;

    // Next counter values; a vsync rise wins over a coincident line increment.
    always_comb begin
        hcnt_nxt = hcnt;
        if (hs_rise) begin
            hcnt_nxt = '0;
        end else if (hcnt != 11'h7FF) begin
            hcnt_nxt = hcnt + 11'd1;
        end
        vcnt_nxt = vcnt;
        if (vs_rise) begin
            vcnt_nxt = '0;
        end else if (hs_rise && (vcnt != 10'h3FF)) begin
            vcnt_nxt = vcnt + 10'd1;
        end
    end

    // Position counters plus line/frame period capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            lcnt        <= '0;
            have_fall   <= 1'b0;
            line_len    <= '0;
            line_cap    <= 1'b0;
            frame_lines <= '0;
            frame_cap   <= 1'b0;
        end else begin
            hcnt      <= hcnt_nxt;
            vcnt      <= vcnt_nxt;
            line_cap  <= hs_fall & have_fall;
            frame_cap <= vs_rise;
            if (hs_fall) begin
                // lcnt holds the clocks elapsed since the previous fall.
                lcnt      <= 11'd1;
                have_fall <= 1'b1;
                if (have_fall) begin
                    line_len <= lcnt;
                end
            end else if (lcnt != 11'h7FF) begin
                lcnt <= lcnt + 11'd1;
            end
            if (vs_rise) begin
                frame_lines <= vcnt;
            end
        end
    end

    // Measurement checks act on the cycle after each capture.
    assign line_err  = line_cap & (line_len != H_TOT);
    assign frame_err = frame_cap & (frame_lines != V_TOT);

    // Lock FSM: find a vsync, measure one whole frame, then police timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            line_bad <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (frame_cap) begin
                        state    <= MEASURE;
                        line_bad <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (frame_cap) begin
                        // The line ending on this vsync still belongs to the frame.
                        if (!line_bad && !line_err && !frame_err) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                        line_bad <= 1'b0;
                    end else if (line_err) begin
                        line_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (line_err || frame_err) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign h_act  = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END);
    assign v_act  = (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
    assign pix_ok = locked & h_act & v_act;

    // Registered pixel stream, zeroed outside the active window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            pixel_valid <= pix_ok;
            pixel_x     <= pix_ok ? 10'(hcnt_nxt - H_START) : '0;
            pixel_y     <= pix_ok ? (vcnt_nxt - V_START) : '0;
            rgb_out     <= pix_ok ? rgb_d2 : '0;
            frame_start <= pix_ok && (hcnt_nxt == H_START) && (vcnt_nxt == V_START);
        end
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink-side counterpart of the VGA timing generator: consumes active-low h/v sync plus 1-bit R/G/B.
- Recovers pixel coordinates and checks the incoming timing against the configured mode.
- Asserts lock once a full frame matches, and flags timing errors.
- Sits at the capture side of loopback and test paths, feeding coordinate-tagged pixels to downstream checkers and frame stores.

Parameters:
- H_TOTAL, 800, clocks per line (hsync falling edge to next hsync falling edge).
- H_ACTIVE, 640, active pixels per line.
- H_BP, 48, clocks from the hsync_n rising edge to the first active pixel.
- V_TOTAL, 525, lines per frame.
- V_ACTIVE, 480, active lines per frame.
- V_BP, 33, lines from the vsync_n rising edge to the first active line.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- vga_h_sync  input  1  horizontal sync, active-low, asynchronous to clk
- vga_v_sync  input  1  vertical sync, active-low, asynchronous to clk
- red_in  input  1  red pixel bit
- green_in  input  1  green pixel bit
- blue_in  input  1  blue pixel bit
- pixel_x  output  10  active-area column, 0..H_ACTIVE-1
- pixel_y  output  10  active-area row, 0..V_ACTIVE-1
- pixel_valid  output  1  pixel_x/pixel_y/rgb_out are valid this cycle
- rgb_out  output  3  {red, green, blue}, aligned with pixel_valid
- frame_start  output  1  one-cycle pulse coincident with pixel (0,0)
- locked  output  1  timing matches parameters
- sync_err  output  1  one-cycle pulse when lock is lost
- line_len  output  11  last measured line period in clocks
- frame_lines  output  10  last measured frame length in lines

Behaviour:
- Reset (async assert, sync-timed release): all outputs 0; FSM = SEARCH; counters 0; synchroniser flops reset to 1 (idle sync level).
- Input path:
  - vga_h_sync and vga_v_sync each pass through a 2-flop synchroniser.
  - RGB inputs pass through an equal 2-flop delay so colour stays aligned with the synced syncs.
  - Edge detect on the synced values: hs_fall, hs_rise, vs_rise.
- Horizontal counter hcnt (11 bits):
  - Cleared to 0 on hs_rise.
  - Otherwise increments, saturating at 2047.
- Line period counter:
  - On hs_fall, line_len <= clocks elapsed since the previous hs_fall; the counter then restarts.
  - The first hs_fall after reset updates nothing.
  - Period saturates at 2047.
- Vertical counter vcnt (10 bits):
  - Increments on each hs_rise.
  - Cleared on vs_rise, and frame_lines <= vcnt at the same time (vcnt value before clearing).
  - Saturates at 1023.
- FSM:
  - SEARCH: wait for vs_rise, then go to MEASURE and clear line_bad.
  - MEASURE:
    - Any line_len != H_TOTAL sets line_bad.
    - On the next vs_rise: if !line_bad and measured lines == V_TOTAL, go to LOCKED.
    - Otherwise stay in MEASURE, clear line_bad and retry on the following frame.
  - LOCKED:
    - Any hs_fall with line_len != H_TOTAL, or any vs_rise with frame_lines != V_TOTAL, is a loss of lock.
    - On loss: sync_err pulses 1 cycle, go to SEARCH, locked <= 0 in the same cycle.
    - Loss is evaluated on the cycle after the capture.
  - locked = (state == LOCKED), registered.
- Output stage (registered, 1 cycle after the synced samples):
  - pixel_valid = locked & H_BP <= hcnt < H_BP+H_ACTIVE & V_BP <= vcnt < V_BP+V_ACTIVE.
  - pixel_x = hcnt - H_BP and pixel_y = vcnt - V_BP when valid; 0 otherwise.
  - rgb_out = delayed RGB when valid; 0 otherwise.
- frame_start = pixel_valid & pixel_x == 0 & pixel_y == 0.
- Total latency from pins to outputs: 3 clocks for both sync and RGB paths.
- Simultaneous hs_rise and vs_rise:
  - vcnt clears; the increment is dropped.
  - The line starting there is vcnt 0.
- Sync glitches shorter than 2 clocks may be missed. No filtering is applied beyond the synchroniser.
- Reset mid-frame: immediate return to SEARCH; lock requires a full clean frame after reset release.

Test Plan:
- Reset, then 3 clean frames at default timing (HS low 96 clocks, VS low 2 lines):
  - locked = 0 through frame 1.
  - locked rises on the 2nd vs_rise.
  - line_len = 800 and frame_lines = 525.
- Locked, pattern rgb = pixel_x[2:0]:
  - Exactly 640×480 pixel_valid cycles per frame.
  - rgb_out == pixel_x[2:0] on every valid cycle.
  - frame_start fires once per frame with pixel_x = pixel_y = 0.
- Locked, one line stretched to 801 clocks:
  - sync_err pulses once; locked = 0; pixel_valid stays 0.
  - Relock after two clean vsync edges.
- Frame of 524 lines while locked:
  - frame_lines = 524, sync_err pulse, FSM in SEARCH.
- Assert rst_n low mid-line for 3 clocks:
  - All outputs 0 asynchronously.
  - No lock until a full 525-line frame completes after release.
- Sync held low for 1 ms (disconnected source):
  - No lock; line_len saturates at 2047 on the next edge.
  - sync_err pulses once if the block was previously locked.
